nand_lut_eval: RTL

- Parametrised, programmable N-input single-output Boolean function unit, stored as a 2^N-entry truth table.
- Successor to the fixed 4-input gate-level function block.
- Adds a registered evaluate path with valid/ready handshake and run-time table reload.
- Adds a self-test sweep FSM that streams every minterm and counts the ones; sits beside datapath logic as a reconfigurable function/self-check element.

---
 rtl/nand_lut_eval.sv | 93 +++++++++
 1 files changed

// File: rtl/nand_lut_eval.sv
// Programmable N-input truth-table function unit with registered evaluate path and self-test sweep.
// Latency: 1 cycle from accept to s_valid. A full sweep is T result cycles plus 1 done cycle.
// Backpressure: in_ready is low while a sweep runs, and cfg_load is ignored until the sweep finishes.
module nand_lut_eval #(
    parameter int                N    = 4,
    parameter logic [(1<<N)-1:0] INIT = 16'h212F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [(1<<N)-1:0]   cfg_table,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        x,
    output logic                s_valid,
    output logic                s,
    output logic [N-1:0]        s_idx,
    input  logic                sweep_start,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic [N:0]          ones_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [(1<<N)-1:0]   table_q;
    logic [N-1:0]        idx_q;
    logic [N:0]          acc_q;

    assign in_ready   = (state_q == ST_IDLE);
    assign sweep_busy = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sweep_start) state_d = ST_RUN;
            // Leave RUN once the last index has been issued, so the counter never wraps into a second pass.
            ST_RUN:  if (&idx_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            table_q    <= INIT;
            idx_q      <= '0;
            acc_q      <= '0;
            s_valid    <= 1'b0;
            s          <= 1'b0;
            s_idx      <= '0;
            sweep_done <= 1'b0;
            ones_count <= '0;
        end else begin
            state_q    <= state_d;
            s_valid    <= 1'b0;
            sweep_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A sweep start takes this slot, so a same-cycle evaluate request produces no result.
                    if (sweep_start) begin
                        idx_q <= '0;
                        acc_q <= '0;
                    end else if (in_valid) begin
                        s       <= table_q[x];
                        s_idx   <= x;
                        s_valid <= 1'b1;
                    end
                    if (cfg_load) table_q <= cfg_table;
                end
                ST_RUN: begin
                    s       <= table_q[idx_q];
                    s_idx   <= idx_q;
                    s_valid <= 1'b1;
                    acc_q   <= acc_q + (N+1)'(table_q[idx_q]);
                    idx_q   <= idx_q + N'(1);
                end
                ST_DONE: begin
                    ones_count <= acc_q;
                    sweep_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
